// File: rtl/wave_render_pkg.sv
// Shared types and constants for the waveform-to-pixel renderer.
package wave_render_pkg;

  localparam int LATENCY = 3;
  localparam int CH_MAX  = 4;

  typedef logic [$clog2(CH_MAX)-1:0] ch_idx_t;

  typedef enum logic {
    MODE_DOT  = 1'b0,
    MODE_LINE = 1'b1
  } mode_e;

endpackage

// File: rtl/wave_pixel_render_if.sv
// Pixel-stream, sample-RAM read port and per-pixel result signals of the renderer.
interface wave_pixel_render_if #(
  parameter int CH  = 2,
  parameter int DW  = 12,
  parameter int AW  = 10,
  parameter int XYW = 11
);
  // pixel_de qualifies pixel_xpos/ypos every cycle and there is no back-pressure;
  // every ram_rd_en pulse is answered by ram_rd_data exactly one cycle later.
  logic [XYW-1:0]   pixel_xpos;
  logic [XYW-1:0]   pixel_ypos;
  logic             pixel_de;
  logic [CH-1:0]    ch_en;
  logic             line_mode;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [CH*DW-1:0] ram_rd_data;
  logic [CH-1:0]    pixel_flag;
  logic             pixel_hit;
  logic [1:0]       pixel_ch;
  logic             pixel_de_o;

  modport master (
    input  pixel_xpos, pixel_ypos, pixel_de, ch_en, line_mode, ram_rd_data,
    output ram_rd_en, ram_rd_addr, pixel_flag, pixel_hit, pixel_ch, pixel_de_o
  );

  modport slave (
    output pixel_xpos, pixel_ypos, pixel_de, ch_en, line_mode, ram_rd_data,
    input  ram_rd_en, ram_rd_addr, pixel_flag, pixel_hit, pixel_ch, pixel_de_o
  );
endinterface

// File: rtl/wave_hit_cmp.sv
// Single-channel hit test: previous-sample register plus dot / connected-line compare.
module wave_hit_cmp
  import wave_render_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          win_i,
  input  logic          first_i,
  input  logic          en_i,
  input  mode_e         mode_i,
  input  logic          below_i,
  input  logic [CW-1:0] rel_y_i,
  input  logic [CW-1:0] cur_i,
  output logic          hit_o
);

  logic [CW-1:0] prev_q;
  logic          prev_vld_q;
  logic [CW-1:0] prev_eff;
  logic [CW-1:0] lo;
  logic [CW-1:0] hi;
  logic          in_rng;

  // A segment never starts from a column left of the window or from before a gap.
  always_comb begin
    prev_eff = (first_i || !prev_vld_q) ? cur_i : prev_q;
    lo       = (prev_eff < cur_i) ? prev_eff : cur_i;
    hi       = (prev_eff < cur_i) ? cur_i : prev_eff;
    if (mode_i == MODE_LINE) begin
      in_rng = (rel_y_i >= lo) && (rel_y_i <= hi);
    end else begin
      in_rng = (rel_y_i == cur_i);
    end
    hit_o = win_i & en_i & ~below_i & in_rng;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_vld_q <= win_i;
      if (win_i) begin
        prev_q <= cur_i;
      end
    end
  end

endmodule

// File: rtl/wave_pixel_render.sv
// Renders stored waveform samples onto the pixel stream with a fixed 3-cycle latency.
module wave_pixel_render
  import wave_render_pkg::*;
#(
  parameter int CH    = 2,
  parameter int DW    = 12,
  parameter int AW    = 10,
  parameter int XYW   = 11,
  parameter int SHIFT = 3,
  parameter int X_ORG = 0,
  parameter int Y_ORG = 48
) (
  input logic clk,
  input logic rst_n,
  wave_pixel_render_if.master bus
);

  localparam int CW = (DW > XYW) ? DW : XYW;
  localparam int unsigned WIN = 1 << AW;

  logic [XYW:0]    xrel;
  logic            in_win;
  logic            first;
  logic [AW-1:0]   rd_addr_d;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic [XYW-1:0]  y0_q, y1_q;
  logic            first0_q, first1_q;
  logic            de0_q, de1_q, win1_q;
  logic [CW:0]     yrel;
  logic            below;
  logic [CW-1:0]   rel_y;
  mode_e           mode;
  logic [CH-1:0]   hit_d;
  ch_idx_t         ch_d;
  logic [CH-1:0]   flag_q;
  logic            hit_q;
  ch_idx_t         ch_q;
  logic            de_o_q;

  // The extra top bit catches xpos < X_ORG as a borrow, which then fails the range test.
  assign xrel   = {1'b0, bus.pixel_xpos} - (XYW+1)'(X_ORG);
  assign in_win = bus.pixel_de & (xrel < (XYW+1)'(WIN));
  assign first  = (bus.pixel_xpos == XYW'(X_ORG));

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (in_win) begin
      rd_addr_d = xrel[AW-1:0];
    end
  end

  assign yrel  = {1'b0, CW'(y1_q)} - (CW+1)'(Y_ORG);
  assign below = yrel[CW];
  assign rel_y = yrel[CW-1:0];
  assign mode  = mode_e'(bus.line_mode);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [CW-1:0] cur;
    assign cur = CW'(bus.ram_rd_data[k*DW +: DW] >> SHIFT);

    wave_hit_cmp #(.CW(CW)) u_cmp (
      .clk     (clk),
      .rst_n   (rst_n),
      .win_i   (win1_q),
      .first_i (first1_q),
      .en_i    (bus.ch_en[k]),
      .mode_i  (mode),
      .below_i (below),
      .rel_y_i (rel_y),
      .cur_i   (cur),
      .hit_o   (hit_d[k])
    );
  end

  // Scanning downward lets the lowest-index hit overwrite the others.
  always_comb begin
    ch_d = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (hit_d[k]) begin
        ch_d = ch_idx_t'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      y0_q      <= '0;
      first0_q  <= 1'b0;
      de0_q     <= 1'b0;
      y1_q      <= '0;
      first1_q  <= 1'b0;
      de1_q     <= 1'b0;
      win1_q    <= 1'b0;
      flag_q    <= '0;
      hit_q     <= 1'b0;
      ch_q      <= '0;
      de_o_q    <= 1'b0;
    end else begin
      rd_en_q   <= in_win;
      rd_addr_q <= rd_addr_d;
      y0_q      <= bus.pixel_ypos;
      first0_q  <= first;
      de0_q     <= bus.pixel_de;
      y1_q      <= y0_q;
      first1_q  <= first0_q;
      de1_q     <= de0_q;
      win1_q    <= rd_en_q;
      flag_q    <= hit_d;
      hit_q     <= |hit_d;
      ch_q      <= ch_d;
      de_o_q    <= de1_q;
    end
  end

  assign bus.ram_rd_en   = rd_en_q;
  assign bus.ram_rd_addr = rd_addr_q;
  assign bus.pixel_flag  = flag_q;
  assign bus.pixel_hit   = hit_q;
  assign bus.pixel_ch    = ch_q;
  assign bus.pixel_de_o  = de_o_q;

endmodule

// File: tb/tb_wave_pixel_render.sv
// Directed bench for wave_pixel_render with a 1-cycle synchronous sample RAM model.
module tb_wave_pixel_render;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  logic [11:0] ram0 [1024];
  logic [11:0] ram1 [1024];

  logic [1:0] f;
  logic [1:0] c;
  logic       h;
  logic       d;

  wave_pixel_render_if #(.CH(2), .DW(12), .AW(10), .XYW(11)) bus ();

  wave_pixel_render dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sample RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_rd_en) begin
      bus.ram_rd_data <= {ram1[bus.ram_rd_addr], ram0[bus.ram_rd_addr]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int x, input int y, input logic de);
    bus.pixel_xpos = 11'(x);
    bus.pixel_ypos = 11'(y);
    bus.pixel_de   = de;
  endtask

  // Drive columns x0..x1 back to back at row y; return the outputs for column xcap.
  task automatic sweep(input int y, input int x0, input int x1, input int xcap,
                       output logic [1:0] fo, output logic [1:0] co,
                       output logic ho, output logic dout);
    fo = 'x; co = 'x; ho = 1'bx; dout = 1'bx;
    for (int i = x0; i <= x1 + 3; i++) begin
      @(negedge clk);
      if (i - 3 == xcap) begin
        fo = bus.pixel_flag; co = bus.pixel_ch; ho = bus.pixel_hit; dout = bus.pixel_de_o;
      end
      if (i <= x1) set_pix(i, y, 1'b1);
      else         set_pix(0, 0, 1'b0);
    end
  endtask

  // Two consecutive columns xa, xb at row y; return the outputs for xb.
  task automatic two_pix(input int xa, input int xb, input int y, output logic [1:0] fo);
    @(negedge clk); set_pix(xa, y, 1'b1);
    @(negedge clk); set_pix(xb, y, 1'b1);
    @(negedge clk); set_pix(0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk); fo = bus.pixel_flag;
    repeat (3) @(negedge clk);
  endtask

  int         ly [5]   = '{57, 58, 75, 98, 99};
  logic [1:0] lexp [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = '0;
      ram1[i] = '0;
    end
    ram0[5]  = 12'd80;
    ram0[9]  = 12'd80;
    ram0[10] = 12'd400;
    bus.ram_rd_data = '0;
    bus.ch_en       = 2'b01;
    bus.line_mode   = 1'b0;
    set_pix(0, 0, 1'b0);
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(bus.ram_rd_en), 0);
    chk("rst_rd_addr", 32'(bus.ram_rd_addr), 0);
    chk("rst_flag", 32'(bus.pixel_flag), 0);
    chk("rst_hit", 32'(bus.pixel_hit), 0);
    chk("rst_ch", 32'(bus.pixel_ch), 0);
    chk("rst_de_o", 32'(bus.pixel_de_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // dot hit, exactly 3 cycles after the pixel
    set_pix(5, 58, 1'b1);
    @(negedge clk); set_pix(0, 0, 1'b0);
    chk("lat_rd_en", 32'(bus.ram_rd_en), 1);
    chk("lat_rd_addr", 32'(bus.ram_rd_addr), 5);
    chk("lat_flag_c1", 32'(bus.pixel_flag), 0);
    @(negedge clk);
    chk("lat_flag_c2", 32'(bus.pixel_flag), 0);
    chk("lat_de_c2", 32'(bus.pixel_de_o), 0);
    @(negedge clk);
    chk("lat_flag_c3", 32'(bus.pixel_flag), 2'b01);
    chk("lat_hit_c3", 32'(bus.pixel_hit), 1);
    chk("lat_ch_c3", 32'(bus.pixel_ch), 0);
    chk("lat_de_c3", 32'(bus.pixel_de_o), 1);
    repeat (3) @(negedge clk);

    sweep(57, 5, 5, 5, f, c, h, d);
    chk("dot_y57_flag", 32'(f), 0);
    chk("dot_y57_de", 32'(d), 1);
    sweep(59, 5, 5, 5, f, c, h, d);
    chk("dot_y59_flag", 32'(f), 0);

    // connected line from 10 (x=9) to 50 (x=10)
    bus.line_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sweep(ly[i], 0, 20, 10, f, c, h, d);
      chk($sformatf("line_x10_y%0d", ly[i]), 32'(f), 32'(lexp[i]));
    end
    sweep(78, 10, 10, 10, f, c, h, d);
    chk("line_gap_y78", 32'(f), 0);
    sweep(98, 10, 10, 10, f, c, h, d);
    chk("line_gap_y98", 32'(f), 2'b01);
    bus.line_mode = 1'b0;

    // window and de qualification
    @(negedge clk); set_pix(1024, 48, 1'b1);
    @(negedge clk); set_pix(0, 0, 1'b0);
    chk("win_rd_en", 32'(bus.ram_rd_en), 0);
    repeat (2) @(negedge clk);
    chk("win_flag", 32'(bus.pixel_flag), 0);
    chk("win_de_o", 32'(bus.pixel_de_o), 1);
    repeat (2) @(negedge clk);
    sweep(48, 0, 0, 0, f, c, h, d);
    chk("win_x0_y48_flag", 32'(f), 2'b01);
    @(negedge clk); set_pix(5, 58, 1'b0);
    @(negedge clk); set_pix(0, 0, 1'b0);
    chk("de0_rd_en", 32'(bus.ram_rd_en), 0);
    chk("de0_addr_held", 32'(bus.ram_rd_addr), 0);
    repeat (2) @(negedge clk);
    chk("de0_flag", 32'(bus.pixel_flag), 0);
    chk("de0_de_o", 32'(bus.pixel_de_o), 0);
    sweep(40, 0, 0, 0, f, c, h, d);
    chk("below_flag", 32'(f), 0);
    chk("below_hit", 32'(h), 0);

    // priority between channels
    ram1[5] = 12'd80;
    ram1[6] = 12'd160;
    bus.ch_en = 2'b11;
    sweep(58, 5, 5, 5, f, c, h, d);
    chk("prio_both_flag", 32'(f), 2'b11);
    chk("prio_both_ch", 32'(c), 0);
    chk("prio_both_hit", 32'(h), 1);
    sweep(68, 6, 6, 6, f, c, h, d);
    chk("prio_ch1only_flag", 32'(f), 2'b10);
    chk("prio_ch1only_ch", 32'(c), 1);
    bus.ch_en = 2'b10;
    sweep(58, 5, 5, 5, f, c, h, d);
    chk("prio_en10_flag", 32'(f), 2'b10);
    chk("prio_en10_ch", 32'(c), 1);
    bus.ch_en = 2'b00;
    sweep(58, 5, 5, 5, f, c, h, d);
    chk("prio_en00_flag", 32'(f), 0);
    chk("prio_en00_hit", 32'(h), 0);
    chk("prio_en00_ch", 32'(c), 0);
    bus.ch_en = 2'b01;

    // first column ignores the stale previous sample
    ram0[1023] = 12'd400;
    ram0[0]    = 12'd80;
    bus.line_mode = 1'b1;
    two_pix(1023, 0, 58, f);
    chk("first_y58", 32'(f), 2'b01);
    two_pix(1023, 0, 78, f);
    chk("first_y78", 32'(f), 0);
    bus.line_mode = 1'b0;

    // reset in the middle of a line
    for (int x = 290; x <= 300; x++) begin
      @(negedge clk); set_pix(x, 48, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_flag", 32'(bus.pixel_flag), 0);
    chk("mrst_hit", 32'(bus.pixel_hit), 0);
    chk("mrst_ch", 32'(bus.pixel_ch), 0);
    chk("mrst_de_o", 32'(bus.pixel_de_o), 0);
    chk("mrst_rd_en", 32'(bus.ram_rd_en), 0);
    chk("mrst_rd_addr", 32'(bus.ram_rd_addr), 0);
    @(negedge clk); rst_n = 1'b1; set_pix(301, 48, 1'b1);
    @(negedge clk);
    chk("mrst_de_o_c1", 32'(bus.pixel_de_o), 0);
    set_pix(302, 48, 1'b1);
    @(negedge clk);
    chk("mrst_de_o_c2", 32'(bus.pixel_de_o), 0);
    set_pix(303, 48, 1'b1);
    @(negedge clk);
    chk("mrst_de_o_c3", 32'(bus.pixel_de_o), 1);
    chk("mrst_flag_c3", 32'(bus.pixel_flag), 2'b01);
    set_pix(0, 0, 1'b0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
